// File: rtl/up_down_stepper.sv
// up_down_stepper: command-side driver for a WIDTH-bit up/down counter.
// Accepts a target over a LOAD/READY handshake, walks its position model
// toward it one ENABLE pulse at a time (paced by GAP idle cycles), and
// cross-checks the counter's VALUE against the model while idle.
module up_down_stepper #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] TARGET,
    input  logic             LOAD,
    output logic             READY,
    input  logic             ABORT,
    output logic             ENABLE,
    output logic             UPDN,
    output logic [WIDTH-1:0] POS,
    output logic             DONE,
    output logic             BUSY,
    input  logic [WIDTH-1:0] VALUE,
    output logic             ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Gap counter reload: the STEP cycle itself accounts for one of the
    // GAP+1 cycles between pulses, so WAIT lasts GAP cycles (counts GAP-1..0).
    localparam logic [3:0] GAP_RELOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [3:0]       gap_q, gap_d;
    logic             updn_q, updn_d;
    logic             err_q, err_d;

    logic             step_up;
    logic [WIDTH-1:0] pos_step;

    // Direction is a plain unsigned compare: no wrap-around shortcut.
    assign step_up  = (tgt_q > pos_q);
    assign pos_step = step_up ? (pos_q + WIDTH'(1)) : (pos_q - WIDTH'(1));

    // State and datapath registers; reset overrides any move in progress.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            tgt_q   <= '0;
            gap_q   <= '0;
            updn_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            gap_q   <= gap_d;
            updn_q  <= updn_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: handshake, stepping, pacing, abort and feedback check.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        gap_d   = gap_q;
        updn_d  = updn_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                // VALUE is only meaningful once the counter has settled.
                if (VALUE != pos_q) begin
                    err_d = 1'b1;
                end
                if (LOAD) begin
                    tgt_d   = TARGET;
                    state_d = (TARGET == pos_q) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                // The pulse on the wire this cycle is always counted, even on
                // abort, so the model never drifts from the real counter.
                pos_d  = pos_step;
                updn_d = step_up;
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (pos_step == tgt_q) begin
                    state_d = S_DONE;
                end else if (GAP == 0) begin
                    state_d = S_STEP;
                end else begin
                    state_d = S_WAIT;
                    gap_d   = GAP_RELOAD;
                end
            end
            S_WAIT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (gap_q == 4'd0) begin
                    state_d = S_STEP;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    assign READY  = (state_q == S_IDLE);
    assign ENABLE = (state_q == S_STEP);
    assign UPDN   = (state_q == S_STEP) ? step_up : updn_q;
    assign DONE   = (state_q == S_DONE);
    assign BUSY   = (state_q != S_IDLE);
    assign POS    = pos_q;
    assign ERR    = err_q;

endmodule
